// File: rtl/fb_transpose_ctrl_pkg.sv
// Shared defaults and helpers for the frame-buffer transpose controller.
package fb_transpose_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_W      = 128;
    localparam int DEF_IMG_H      = 128;
    localparam int DEF_ADDR_WIDTH = 14;

    // Output skid holds at most this many pixels, counting the read in flight.
    localparam logic [2:0] SKID_LIMIT = 3'd2;

    typedef logic [1:0] skid_cnt_t;

    // Counter width for a modulo-n counter; never returns less than 1.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fb_out_skid.sv
// Two-entry valid/ready FIFO carrying {data, last, eof}; entry 0 is the head.
module fb_out_skid
    import fb_transpose_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  push_eof_i,
    input  logic                  pop_ready_i,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_last_o,
    output logic                  pop_eof_o,
    output skid_cnt_t             count_o
);

    localparam int EW = DATA_WIDTH + 2;

    logic [EW-1:0] e0_q, e0_d;
    logic [EW-1:0] e1_q, e1_d;
    skid_cnt_t     cnt_q, cnt_d;
    logic [EW-1:0] in_s;
    logic          pop_s;

    // Next-state for the two entries and occupancy on push/pop combinations.
    always_comb begin
        in_s  = {push_data_i, push_last_i, push_eof_i};
        pop_s = (cnt_q != 2'd0) && pop_ready_i;
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push_valid_i, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_d  = in_s;
                    cnt_d = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    e1_d  = in_s;
                    cnt_d = 2'd2;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = in_s;
                end else begin
                    e0_d = e1_q;
                    e1_d = in_s;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= {EW{1'b0}};
            e1_q  <= {EW{1'b0}};
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign pop_valid_o = (cnt_q != 2'd0);
    assign pop_data_o  = e0_q[EW-1:2];
    assign pop_last_o  = e0_q[1];
    assign pop_eof_o   = e0_q[0];
    assign count_o     = cnt_q;

endmodule

// File: rtl/fb_transpose_ctrl.sv
// Ping-pong frame-buffer sequencer: row-major writes into one bank while a
// completed bank is read back column-major through a 2-entry output skid.
module fb_transpose_ctrl
    import fb_transpose_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_eof,
    output logic                  fb_wr_en,
    output logic [ADDR_WIDTH:0]   fb_wr_addr,
    output logic [DATA_WIDTH-1:0] fb_wr_data,
    output logic [ADDR_WIDTH:0]   fb_rd_addr,
    input  logic [DATA_WIDTH-1:0] fb_rd_data,
    output logic [1:0]            bank_full
);

    localparam int N  = IMG_W * IMG_H;
    localparam int RW = cnt_width(IMG_H);
    localparam int CW = cnt_width(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] WA_LAST  = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);
    localparam logic [RW-1:0]         R_LAST   = RW'(IMG_H - 1);
    localparam logic [CW-1:0]         C_LAST   = CW'(IMG_W - 1);

    logic                  wb_q, wb_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  rb_q, rb_d;
    logic [RW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic [ADDR_WIDTH-1:0] ra_q, ra_d;
    logic [ADDR_WIDTH:0]   rd_addr_q, rd_addr_d;
    logic                  infl_valid_q, infl_last_q, infl_eof_q;

    logic                  s_hs_s;
    logic                  skid_pop_s;
    skid_cnt_t             skid_cnt_s;
    logic [2:0]            occ_s;
    logic                  rd_issue_s;
    logic                  tag_last_s, tag_eof_s;
    logic [1:0]            set_mask_s, clr_mask_s;

    // Handshakes, read-issue decision and the tags of the pixel being issued.
    always_comb begin
        s_ready    = !rst && !bank_full_q[wb_q];
        s_hs_s     = s_valid && s_ready;
        skid_pop_s = m_valid && m_ready;
        // A pop this cycle frees a slot in time for the read issued now.
        occ_s      = {1'b0, skid_cnt_s} + {2'b00, infl_valid_q} - {2'b00, skid_pop_s};
        rd_issue_s = !rst && bank_full_q[rb_q] && (occ_s < SKID_LIMIT);
        tag_last_s = (r_q == R_LAST);
        tag_eof_s  = tag_last_s && (c_q == C_LAST);
    end

    // Next-state for the write pointer, the column-major read walk and bank flags.
    always_comb begin
        wb_d       = wb_q;
        wa_d       = wa_q;
        rb_d       = rb_q;
        r_d        = r_q;
        c_d        = c_q;
        ra_d       = ra_q;
        rd_addr_d  = rd_addr_q;
        set_mask_s = 2'b00;
        clr_mask_s = 2'b00;
        if (s_hs_s) begin
            if (wa_q == WA_LAST) begin
                wa_d             = {ADDR_WIDTH{1'b0}};
                wb_d             = ~wb_q;
                set_mask_s[wb_q] = 1'b1;
            end else begin
                wa_d = wa_q + ADDR_WIDTH'(1);
            end
        end else begin
            wa_d = wa_q;
        end
        if (rd_issue_s) begin
            rd_addr_d = {rb_q, ra_q};
            if (r_q == R_LAST) begin
                r_d = {RW{1'b0}};
                if (c_q == C_LAST) begin
                    c_d              = {CW{1'b0}};
                    ra_d             = {ADDR_WIDTH{1'b0}};
                    rb_d             = ~rb_q;
                    clr_mask_s[rb_q] = 1'b1;
                end else begin
                    // Top of the next column is simply its column index.
                    c_d  = c_q + CW'(1);
                    ra_d = ADDR_WIDTH'(c_q) + ADDR_WIDTH'(1);
                end
            end else begin
                r_d  = r_q + RW'(1);
                ra_d = ra_q + ROW_STEP;
            end
        end else begin
            rd_addr_d = rd_addr_q;
        end
        // Set and clear always target different banks, so both apply.
        bank_full_d = (bank_full_q | set_mask_s) & ~clr_mask_s;
    end

    // State registers, including the in-flight tag stage matching RAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q         <= 1'b0;
            wa_q         <= {ADDR_WIDTH{1'b0}};
            bank_full_q  <= 2'b00;
            rb_q         <= 1'b0;
            r_q          <= {RW{1'b0}};
            c_q          <= {CW{1'b0}};
            ra_q         <= {ADDR_WIDTH{1'b0}};
            rd_addr_q    <= {(ADDR_WIDTH + 1){1'b0}};
            infl_valid_q <= 1'b0;
            infl_last_q  <= 1'b0;
            infl_eof_q   <= 1'b0;
        end else begin
            wb_q         <= wb_d;
            wa_q         <= wa_d;
            bank_full_q  <= bank_full_d;
            rb_q         <= rb_d;
            r_q          <= r_d;
            c_q          <= c_d;
            ra_q         <= ra_d;
            rd_addr_q    <= rd_addr_d;
            infl_valid_q <= rd_issue_s;
            infl_last_q  <= rd_issue_s && tag_last_s;
            infl_eof_q   <= rd_issue_s && tag_eof_s;
        end
    end

    // Frame-buffer port drive; the read address holds its last value when idle.
    always_comb begin
        fb_wr_en   = s_hs_s;
        fb_wr_data = s_data;
        if (rst) begin
            fb_wr_addr = {(ADDR_WIDTH + 1){1'b0}};
            fb_rd_addr = {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            fb_wr_addr = {wb_q, wa_q};
            fb_rd_addr = rd_issue_s ? {rb_q, ra_q} : rd_addr_q;
        end
    end

    assign bank_full = bank_full_q;

    fb_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (infl_valid_q),
        .push_data_i  (fb_rd_data),
        .push_last_i  (infl_last_q),
        .push_eof_i   (infl_eof_q),
        .pop_ready_i  (m_ready),
        .pop_valid_o  (m_valid),
        .pop_data_o   (m_data),
        .pop_last_o   (m_last),
        .pop_eof_o    (m_eof),
        .count_o      (skid_cnt_s)
    );

endmodule

// File: tb/tb_fb_transpose_ctrl.sv
// Directed bench for fb_transpose_ctrl with a 4x4 image and a behavioural RAM.
module tb_fb_transpose_ctrl;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last, m_eof;
    logic          fb_wr_en;
    logic [AW:0]   fb_wr_addr, fb_rd_addr;
    logic [DW-1:0] fb_wr_data, fb_rd_data;
    logic [1:0]    bank_full;

    logic [DW-1:0] mem [0:(2**(AW+1))-1];

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int rdy_mode = 1;
    int in_hs = 0;
    int out_hs = 0;
    int last_in_cyc = -1;
    int first_mv_cyc = -1;
    int rise_cyc = -1;
    int rel_cyc = 0;
    logic chk_sready = 1'b0;
    logic sr_watch = 1'b0;
    logic hold_v = 1'b0;
    logic [DW+1:0] hold_val = '0;
    logic wb_m = 1'b0;
    logic [AW-1:0] wa_m = '0;
    logic [AW:0] prev_rd_addr = '0;
    logic [AW:0] rise_prev_addr = '0;
    logic [DW-1:0] in_q[$];
    logic [DW+1:0] exp_q[$];

    fb_transpose_ctrl #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_eof      (m_eof),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .fb_rd_addr (fb_rd_addr),
        .fb_rd_data (fb_rd_data),
        .bank_full  (bank_full)
    );

    always #5 clk = ~clk;

    // Behavioural dual-bank RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (fb_wr_en) mem[fb_wr_addr] <= fb_wr_data;
        fb_rd_data <= mem[fb_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue a row-major frame base..base+15 and its column-major expectation.
    task automatic add_frame(input int base);
        for (int i = 0; i < W * H; i++) in_q.push_back(DW'(base + i));
        for (int c = 0; c < W; c++)
            for (int r = 0; r < H; r++)
                exp_q.push_back({DW'(base + r * W + c), 1'(r == H - 1), 1'((r == H - 1) && (c == W - 1))});
    endtask

    // One clock: drive at the falling edge, then sample and score.
    task automatic cyc();
        logic [DW+1:0] o;
        logic [DW+1:0] e;
        @(negedge clk);
        s_valid = (in_q.size() != 0);
        s_data  = s_valid ? in_q[0] : '0;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(1, 0));
        endcase
        #1;
        o = {m_data, m_last, m_eof};
        if (hold_v && !rst) check("stall_hold", {m_valid, o}, {1'b1, hold_val});
        if (chk_sready && s_valid) check("s_ready_kept", s_ready, 1'b1);
        if (!rst && s_valid && s_ready) begin
            check("wr_port", {fb_wr_en, fb_wr_addr, fb_wr_data}, {1'b1, wb_m, wa_m, in_q[0]});
            if (wa_m == AW'(W * H - 1)) begin
                wa_m = '0;
                wb_m = ~wb_m;
            end else begin
                wa_m = wa_m + 1'b1;
            end
            void'(in_q.pop_front());
            in_hs++;
            last_in_cyc = cyc_n;
        end
        if (!rst && m_valid && m_ready) begin
            check("out_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_pix", o, e);
            end
            out_hs++;
        end
        if (first_mv_cyc < 0 && m_valid === 1'b1) first_mv_cyc = cyc_n;
        if (sr_watch && rise_cyc < 0 && s_ready === 1'b1) begin
            rise_cyc = cyc_n;
            rise_prev_addr = prev_rd_addr;
        end
        hold_v = !rst && m_valid && !m_ready;
        hold_val = o;
        prev_rd_addr = fb_rd_addr;
        cyc_n++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        check("drain", in_q.size() + exp_q.size(), 0);
    endtask

    task automatic do_reset();
        in_q.delete();
        exp_q.delete();
        rst = 1'b1;
        cyc();
        cyc();
        check("rst_flags", {s_ready, m_valid, m_last, m_eof, fb_wr_en, bank_full}, 0);
        check("rst_buses", {m_data, fb_wr_addr, fb_rd_addr}, 0);
        rst = 1'b0;
        wb_m = 1'b0;
        wa_m = '0;
        hold_v = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        do_reset();

        // Single frame, latency of first output
        rdy_mode = 1;
        first_mv_cyc = -1;
        add_frame(0);
        drain(200);
        check("first_valid_latency", first_mv_cyc - last_in_cyc, 3);
        check("single_banks_idle", bank_full, 2'b00);

        // Back-to-back frames, s_ready must never drop
        do_reset();
        chk_sready = 1'b1;
        add_frame(0);
        add_frame(100);
        drain(300);
        chk_sready = 1'b0;

        // Three frames against a stalled sink
        rdy_mode = 0;
        add_frame(8'h30);
        add_frame(8'h60);
        add_frame(8'h90);
        n = 0;
        while (in_q.size() > W * H && n < 200) begin
            cyc();
            n++;
        end
        repeat (4) cyc();
        check("both_full", bank_full, 2'b11);
        check("s_ready_low", s_ready, 1'b0);
        check("inputs_left", in_q.size(), W * H);
        rise_cyc = -1;
        sr_watch = 1'b1;
        rdy_mode = 1;
        rel_cyc = cyc_n;
        drain(300);
        sr_watch = 1'b0;
        check("s_ready_rise_cycle", rise_cyc - rel_cyc, 14);
        check("rise_after_last_issue", rise_prev_addr, 5'h0F);

        // Random sink backpressure over four frames
        rdy_mode = 2;
        add_frame(8'h11);
        add_frame(8'h40);
        add_frame(8'h80);
        add_frame(8'hC0);
        drain(600);
        check("random_banks_idle", bank_full, 2'b00);

        // Reset after 7 inputs
        rdy_mode = 1;
        in_hs = 0;
        add_frame(8'h20);
        n = 0;
        while (in_hs < 7 && n < 100) begin
            cyc();
            n++;
        end
        check("seven_inputs", in_hs, 7);
        do_reset();

        // Reset after 5 outputs
        out_hs = 0;
        add_frame(8'h50);
        n = 0;
        while (out_hs < 5 && n < 100) begin
            cyc();
            n++;
        end
        check("five_outputs", out_hs, 5);
        do_reset();

        // Clean frame after resets, no stale pixels
        add_frame(0);
        drain(200);
        repeat (4) cyc();
        check("final_idle", {m_valid, bank_full}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
